nbit_serial_sub: RTL and testbench



---
 rtl/nbit_serial_sub_pkg.sv | 18 +
 rtl/nbit_serial_sub_full_subtractor.sv | 15 +
 rtl/nbit_serial_sub.sv | 99 +++++++++
 tb/tb_nbit_serial_sub.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/nbit_serial_sub_pkg.sv
// rtl/nbit_serial_sub_pkg.sv - shared state encoding and counter sizing for the serial subtractor
package nbit_serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int N_DEFAULT = 4;
  localparam int CW        = $clog2(N_DEFAULT);

  // Never narrower than one bit, so N=2 still gets a usable counter.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nbit_serial_sub_full_subtractor.sv
// rtl/nbit_serial_sub_full_subtractor.sv - one-bit full subtractor cell, x - y - bi
module full_subtractor
  import nbit_serial_sub_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/nbit_serial_sub.sv
// rtl/nbit_serial_sub.sv - bit-serial N-bit subtractor, LSB first, start/done handshake
module nbit_serial_sub
  import nbit_serial_sub_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         bout
);

  localparam int                CNT_W    = cnt_width(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  state_e           state_q;
  logic [N-1:0]     sa_q, sb_q, res_q, diff_q;
  logic [N-1:0]     sa_d, sb_d, res_d;
  logic             br_q, bout_q, busy_q, done_q;
  logic [CNT_W-1:0] cnt_q;
  logic             d_w, bo_w;

  full_subtractor u_fs (
    .x  (sa_q[0]),
    .y  (sb_q[0]),
    .bi (br_q),
    .d  (d_w),
    .bo (bo_w)
  );

  assign sa_d  = sa_q >> 1;
  assign sb_d  = sb_q >> 1;
  assign res_d = {d_w, res_q[N-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            sa_q    <= a;
            sb_q    <= b;
            br_q    <= bin;
            res_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          sa_q  <= sa_d;
          sb_q  <= sb_d;
          br_q  <= bo_w;
          res_q <= res_d;
          cnt_q <= cnt_q + 1'b1;
          // Last bit: publish the result on the same edge that enters DONE.
          if (cnt_q == CNT_LAST) begin
            diff_q  <= res_d;
            bout_q  <= bo_w;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_nbit_serial_sub.sv
// tb/tb_nbit_serial_sub.sv - directed and exhaustive bench for nbit_serial_sub with a result scoreboard
module tb_nbit_serial_sub;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] a, b;
  logic         bin;
  logic         busy, done, bout;
  logic [N-1:0] diff;

  int checks = 0;
  int errors = 0;
  logic [N:0] exp_q[$];

  nbit_serial_sub #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {borrow, diff} from a plain N+1 bit unsigned subtraction.
  function automatic logic [N:0] ref_sub(input logic [N-1:0] x, input logic [N-1:0] y, input logic bi);
    logic [N:0] t;
    t = {1'b0, x} - {1'b0, y} - {{N{1'b0}}, bi};
    return t;
  endfunction

  task automatic drive(input logic [N-1:0] x, input logic [N-1:0] y, input logic bi);
    a     = x;
    b     = y;
    bin   = bi;
    start = 1'b1;
    exp_q.push_back(ref_sub(x, y, bi));
  endtask

  // Entered at the first negedge after the accept edge.
  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 1;
    bcnt = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_result(input string tag);
    logic [N:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : {(N+1){1'bx}};
    chk(tag, {27'd0, bout, diff}, {27'd0, e});
  endtask

  task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y, input logic bi,
                        input string tag, input bit timing);
    int cyc, bc;
    @(negedge clk);
    drive(x, y, bi);
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, bc);
    chk({tag, " done"}, {31'd0, done}, 32'd1);
    if (timing) begin
      chk({tag, " latency"}, cyc, N + 1);
      chk({tag, " busy_cycles"}, bc, N);
    end
    check_result(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, bc, dc;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    #12;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset diff", {28'd0, diff}, 32'd0);
    chk("reset bout", {31'd0, bout}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op(4'd7,  4'd3,  1'b0, "basic_7_3", 1'b1);
    run_op(4'd2,  4'd5,  1'b0, "under_2_5", 1'b1);
    run_op(4'd0,  4'd0,  1'b1, "bin_0_0_1", 1'b0);
    run_op(4'd15, 4'd15, 1'b0, "eq_15_15",  1'b0);

    // start held through RUN with moving operands
    @(negedge clk);
    drive(4'd3, 4'd1, 1'b0);
    @(negedge clk);
    a = 4'd12; b = 4'd7; bin = 1'b1;
    @(negedge clk);
    a = 4'd9;  b = 4'd14;
    @(negedge clk);
    start = 1'b0;
    dc = 0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) begin
        dc++;
        if (dc == 1) check_result("held_start");
      end
      @(negedge clk);
    end
    chk("held_start pulses", dc, 1);

    // back-to-back accept from DONE
    run_op(4'd12, 4'd2, 1'b0, "b2b_first", 1'b0);
    drive(4'd9, 4'd4, 1'b0);
    @(negedge clk);
    start = 1'b0;
    chk("b2b busy_next", {31'd0, busy}, 32'd1);
    chk("b2b diff_held", {28'd0, diff}, 32'd10);
    wait_done(cyc, bc);
    chk("b2b latency", cyc, N + 1);
    check_result("b2b_second");

    // async reset in the middle of RUN at cnt=2
    @(negedge clk);
    a = 4'd6; b = 4'd2; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst done", {31'd0, done}, 32'd0);
    chk("midrst diff", {28'd0, diff}, 32'd0);
    chk("midrst bout", {31'd0, bout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dc = 0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) dc++;
    end
    chk("midrst no_done", dc, 0);
    run_op(4'd8, 4'd1, 1'b0, "post_reset", 1'b1);

    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int z = 0; z < 2; z++)
          run_op(x[N-1:0], y[N-1:0], z[0], "sweep", 1'b0);

    chk("scoreboard empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
